fetch_stage: RTL

//  Instruction-fetch stage of the uDLX pipeline. Owns the PC, drives the read

---
 rtl/fetch_stage_pkg.sv | 29 ++
 rtl/fetch_stage_if.sv | 30 +++
 rtl/fetch_queue.sv | 88 ++++++++
 rtl/fetch_stage.sv | 72 +++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared uDLX fetch definitions: default widths, reset PC, NOP encoding,
// queue occupancy states and fetch-entry sizing.
package fetch_stage_pkg;

  localparam int unsigned UDLX_DATA_WIDTH = 32;
  localparam int unsigned UDLX_ADDR_WIDTH = 32;
  localparam int unsigned UDLX_RESET_PC   = 0;
  localparam logic [31:0] UDLX_NOP        = 32'h0000_0000;

  typedef enum logic [1:0] {
    Q_EMPTY = 2'd0,
    Q_ONE   = 2'd1,
    Q_TWO   = 2'd2
  } queue_state_e;

  function automatic logic [1:0] queue_count(queue_state_e s);
    case (s)
      Q_ONE:   return 2'd1;
      Q_TWO:   return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

  // A fetch entry packs {instr, pc, npc}.
  function automatic int entry_width(int data_w, int addr_w);
    return data_w + 2 * addr_w;
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: control inputs, instruction ROM read port and the
// valid/ready hand-off to decode.
interface fetch_stage_if import fetch_stage_pkg::*; #(
  parameter int DATA_WIDTH = UDLX_DATA_WIDTH,
  parameter int ADDR_WIDTH = UDLX_ADDR_WIDTH
);

  logic                  fetch_en;
  logic                  redirect;
  logic [ADDR_WIDTH-1:0] redirect_pc;
  logic                  rom_rd_ena;
  logic [ADDR_WIDTH-1:0] rom_address;
  logic [DATA_WIDTH-1:0] rom_data;
  logic                  if_valid;
  logic                  id_ready;
  logic [DATA_WIDTH-1:0] if_instr;
  logic [ADDR_WIDTH-1:0] if_pc;
  logic [ADDR_WIDTH-1:0] if_npc;

  modport master (
    input  fetch_en, redirect, redirect_pc, rom_data, id_ready,
    output rom_rd_ena, rom_address, if_valid, if_instr, if_pc, if_npc
  );

  modport slave (
    output fetch_en, redirect, redirect_pc, rom_data, id_ready,
    input  rom_rd_ena, rom_address, if_valid, if_instr, if_pc, if_npc
  );

endinterface

// File: rtl/fetch_queue.sv
// Two-entry fetch FIFO with push/pop/flush; the head entry is a register so
// decode sees stable outputs while stalled.
module fetch_queue import fetch_stage_pkg::*; #(
  parameter int DATA_WIDTH = UDLX_DATA_WIDTH,
  parameter int ADDR_WIDTH = UDLX_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] push_instr,
  input  logic [ADDR_WIDTH-1:0] push_pc,
  input  logic [ADDR_WIDTH-1:0] push_npc,
  output logic                  head_valid,
  output logic [DATA_WIDTH-1:0] head_instr,
  output logic [ADDR_WIDTH-1:0] head_pc,
  output logic [ADDR_WIDTH-1:0] head_npc,
  output logic [1:0]            count
);

  localparam int ENTRY_W = entry_width(DATA_WIDTH, ADDR_WIDTH);

  queue_state_e         state_q, state_d;
  logic [ENTRY_W-1:0]   head_q, tail_q, push_entry;
  logic                 head_from_push, head_from_tail, tail_from_push;

  assign push_entry = {push_instr, push_pc, push_npc};

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= Q_EMPTY;
    else        state_q <= state_d;
  end

  // Flush wins over a same-cycle push; push into a full queue cannot occur.
  always_comb begin
    state_d        = state_q;
    head_from_push = 1'b0;
    head_from_tail = 1'b0;
    tail_from_push = 1'b0;
    if (flush) begin
      state_d = Q_EMPTY;
    end else begin
      case (state_q)
        Q_EMPTY: begin
          if (push) begin
            state_d        = Q_ONE;
            head_from_push = 1'b1;
          end
        end
        Q_ONE: begin
          case ({push, pop})
            2'b10: begin
              state_d        = Q_TWO;
              tail_from_push = 1'b1;
            end
            2'b01:   state_d        = Q_EMPTY;
            2'b11:   head_from_push = 1'b1;
            default: state_d        = Q_ONE;
          endcase
        end
        Q_TWO: begin
          if (pop) begin
            head_from_tail = 1'b1;
            if (push) tail_from_push = 1'b1;
            else      state_d        = Q_ONE;
          end
        end
        default: state_d = Q_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)              head_q <= '0;
    else if (head_from_push) head_q <= push_entry;
    else if (head_from_tail) head_q <= tail_q;
  end

  always_ff @(posedge clk) begin
    if (tail_from_push) tail_q <= push_entry;
  end

  assign head_valid = (state_q != Q_EMPTY);
  assign count      = queue_count(state_q);
  assign {head_instr, head_pc, head_npc} = head_q;

endmodule

// File: rtl/fetch_stage.sv
// uDLX instruction fetch: PC register, ROM read issue, inflight/kill tracking
// and a two-entry queue feeding decode.
module fetch_stage import fetch_stage_pkg::*; #(
  parameter int                    DATA_WIDTH = UDLX_DATA_WIDTH,
  parameter int                    ADDR_WIDTH = UDLX_ADDR_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(UDLX_RESET_PC)
) (
  input  logic           clk,
  input  logic           rst_n,
  fetch_stage_if.master  bus
);

  logic [ADDR_WIDTH-1:0] pc_p0;
  logic [ADDR_WIDTH-1:0] req_pc_p1;
  logic                  vld_p1, kill_p1;
  logic                  issue, pop, push;
  logic                  q_valid;
  logic [1:0]            q_count;
  logic [2:0]            occupancy, limit;

  // Issue only while the queue can absorb every word already owed to it.
  assign pop       = q_valid & bus.id_ready & ~bus.redirect;
  assign occupancy = {1'b0, q_count} + {2'b00, vld_p1};
  assign limit     = 3'd2 + {2'b00, pop};
  assign issue     = rst_n & bus.fetch_en & ~bus.redirect & (occupancy < limit);

  assign bus.rom_rd_ena  = issue;
  assign bus.rom_address = pc_p0;

  // Stage p0 -> p1: ROM request outstanding
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_p0   <= RESET_PC;
      vld_p1  <= 1'b0;
      kill_p1 <= 1'b0;
    end else begin
      if (bus.redirect) pc_p0 <= bus.redirect_pc;
      else if (issue)   pc_p0 <= pc_p0 + ADDR_WIDTH'(1);
      vld_p1  <= issue;
      kill_p1 <= bus.redirect;
    end
  end

  always_ff @(posedge clk) begin
    if (issue) req_pc_p1 <= pc_p0;
  end

  // Stage p1 -> queue: ROM word returns and is captured
  assign push = vld_p1 & ~kill_p1;

  fetch_queue #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_queue (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .pop        (pop),
    .flush      (bus.redirect),
    .push_instr (bus.rom_data),
    .push_pc    (req_pc_p1),
    .push_npc   (req_pc_p1 + ADDR_WIDTH'(1)),
    .head_valid (q_valid),
    .head_instr (bus.if_instr),
    .head_pc    (bus.if_pc),
    .head_npc   (bus.if_npc),
    .count      (q_count)
  );

  assign bus.if_valid = q_valid;

endmodule
